// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller for the pipelined ARM32 core.
// Evaluates the ARM condition field, runs a req/ack transaction towards the data
// memory with a timeout, steers word/byte lanes and issues a one-cycle load
// writeback. Optional build macro: MEM_SIGN_EXT_EN (signed byte loads).
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                byte_mode,
    input  logic                ld_signed,
    input  logic [3:0]          cond,
    input  logic [3:0]          status_nzcv,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [3:0]          rd,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_valid,
    output logic [3:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                fault
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] LANE_MASK  = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB, FAULT} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BYTES-1:0]    be_q;
    logic                we_q;
    logic                byte_q;
    logic [LANE_W-1:0]   lane_q;
    logic [3:0]          rd_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                cond_pass;
    logic                accept;
    logic [LANE_W-1:0]   lane_in;
    logic [7:0]          byte_sel;
    logic                sign_fill;
    logic [DATA_W-1:0]   load_result;

    // ARM condition-code evaluation; bit3 = N, bit2 = Z, bit1 = C, bit0 = V.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        unique case (c)
            4'h0: cond_check = z;
            4'h1: cond_check = !z;
            4'h2: cond_check = cy;
            4'h3: cond_check = !cy;
            4'h4: cond_check = n;
            4'h5: cond_check = !n;
            4'h6: cond_check = v;
            4'h7: cond_check = !v;
            4'h8: cond_check = cy & !z;
            4'h9: cond_check = !cy | z;
            4'hA: cond_check = (n == v);
            4'hB: cond_check = (n != v);
            4'hC: cond_check = !z & (n == v);
            4'hD: cond_check = z | (n != v);
            4'hE: cond_check = 1'b1;
            4'hF: cond_check = 1'b0;
        endcase
    endfunction

`ifdef MEM_SIGN_EXT_EN
    logic signed_q;
`else
    // Signed byte loads are not supported in this build; the port is kept.
    logic ld_signed_unused;
    assign ld_signed_unused = ld_signed;
`endif

    assign cond_pass = cond_check(cond, status_nzcv);
    assign accept    = instr_valid & (is_load | is_store) & cond_pass
                     & ((state_q == IDLE) | (state_q == WB));
    assign lane_in   = LANE_W'(addr & LANE_MASK);

    // Select the addressed byte of the read data and extend it to a full word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        byte_sel = mem_rdata[7:0];
        for (int i = 0; i < BYTES; i++) begin
            if (lane_q == LANE_W'(i)) byte_sel = mem_rdata[8*i +: 8];
        end
`ifdef MEM_SIGN_EXT_EN
        sign_fill = signed_q & byte_sel[7];
`else
        sign_fill = 1'b0;
`endif
        load_result = mem_rdata;
        if (byte_q) begin
            load_result = DATA_W'(byte_sel);
            if (sign_fill) load_result = load_result | ~DATA_W'(8'hFF);
        end
    end

    // Next-state logic: accept, wait for ack with timeout, writeback, fault.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            WB: begin
                state_d = accept ? ACCESS : IDLE;
                if (accept) cnt_d = '0;
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = we_q ? IDLE : WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: state_d = IDLE;
        endcase
    end

    // Control registers: state, timeout counter, sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Request/writeback registers: captured on accept, load data captured on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these are plain registers (not a RAM), so resetting them is cheap and keeps outputs at 0.
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
`ifdef MEM_SIGN_EXT_EN
            signed_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= addr & ~LANE_MASK;
                wdata_q <= byte_mode ? {BYTES{store_data[7:0]}} : store_data;
                be_q    <= byte_mode ? (BYTES'(1) << lane_in) : {BYTES{1'b1}};
                we_q    <= is_store;
                byte_q  <= byte_mode;
                lane_q  <= lane_in;
                rd_q    <= rd;
`ifdef MEM_SIGN_EXT_EN
                signed_q <= ld_signed;
`endif
            end
            if ((state_q == ACCESS) && mem_ack && !we_q) rdata_q <= load_result;
        end
    end

    assign stall     = accept | (state_q == ACCESS);
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be_q : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = (state_q == WB);
    assign wb_rd     = rd_q;
    assign wb_data   = rdata_q;
    assign fault     = fault_q;

endmodule
